step_judge: RTL and testbench
=============================

Name: step_judge

Overview:
- Player-side input judge for the dance game; the receiving end of the per-player button bus (4 arrow buttons per player).
- Debounces the raw arrow buttons and detects press edges.
- Compares presses against the arrow pattern shown for the current beat window, and keeps BCD hit and error tallies for the seven-segment driver.
- The top instantiates it once per player: btn_ctr_in[3:0] and btn_ctr_in[7:4].

Parameters:
- DEB_CYCLES, 1000, consecutive stable cycles required to accept a debounced level change (synthesis uses 4_000_000).
- DEB_W, 22, width of the debounce counter; must hold DEB_CYCLES.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- en  in  1  game running (from the mode switch).
- clr  in  1  synchronous score clear, one-cycle pulse (start button).
- beat  in  1  one-cycle pulse marking the end of a beat window (derived from clk_gamespeed).
- arrow  in  4  target pattern for the current window; bit i = arrow i; 0 = rest beat.
- btn  in  4  raw asynchronous arrow buttons.
- btn_db  out  4  debounced button levels.
- hit_bcd  out  16  4-digit BCD hit count.
- err_bcd  out  16  4-digit BCD error count (the errorpress value).
- judge  out  2  last verdict: 00 none, 01 hit, 10 miss.
- judge_valid  out  1  one-cycle pulse when judge updates.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - btn_db=0, hit_bcd=0, err_bcd=0, judge=00, judge_valid=0.
  - press mask cleared; FSM=IDLE; synchronizers and debounce counters cleared.
- Synchronizer and debounce, per bit:
  - 2-FF synchronizer feeds the debouncer.
  - Counter runs while the sync output differs from btn_db[i]; it resets whenever they are equal.
  - When the count reaches DEB_CYCLES-1 with inputs still differing, btn_db[i] toggles next edge.
  - Latency from raw edge to btn_db edge: 2 + DEB_CYCLES cycles.
  - A glitch shorter than DEB_CYCLES never changes btn_db.
- Press detection: press[i] = btn_db[i] rising edge, a one-cycle pulse. Releases are ignored.
- FSM:
  - IDLE: en=0. Mask held at 0; no verdicts; counters hold.
  - IDLE -> ARMED when en=1.
  - ARMED: waits for the first beat so no partial window is judged. Presses are ignored.
  - ARMED -> PLAY on beat; that beat produces no verdict.
  - PLAY -> IDLE whenever en=0. Takes priority; the mask is cleared with no verdict.
- PLAY window rules:
  - Each press with press & arrow != 0 sets the matching mask bits (mask |= press & arrow).
  - Any press with press & ~arrow != 0 is a wrong press: err +1, at most 1 per cycle.
  - On beat with arrow != 0:
    - hit if (mask_next & arrow) == arrow, where mask_next includes same-cycle presses.
    - otherwise miss.
  - On beat with arrow == 0: no verdict, judge_valid stays 0.
  - After beat, the mask clears to 0.
- Verdict timing:
  - judge and judge_valid are registered one cycle after the beat cycle.
  - A hit adds hit +1; a miss adds err +1.
- Counter arithmetic and timing:
  - Counters are BCD, each digit 0-9 with carry, saturating at 9999.
  - In the cycle after a beat-cycle wrong press that also misses, err increments by 2, saturating. This is the only +2 case.
  - A wrong press increments err in the next cycle.
  - A miss increments err in the verdict cycle, one cycle after the beat.
- Priority: rst_n > clr > normal operation.
  - clr zeroes hit_bcd, err_bcd and judge, and clears the mask.
  - clr does not change FSM state or debounce state.
  - clr in the beat cycle suppresses that verdict.
- arrow is sampled only through the mask and beat logic; a change of arrow mid-window does not clear the mask.

Decomposition:
- Shared package dr_pkg holds:
  - JUDGE_NONE/HIT/MISS codes.
  - FSM state encoding (IDLE, ARMED, PLAY).
  - BCD_MAX = 16'h9999.
  - A BCD increment function taking a 0-2 increment and saturating.
- Sub-module btn_debounce: 1-bit synchronizer plus debouncer, instantiated 4x.

Test Plan (DEB_CYCLES=4):
- Reset and debounce:
  - Stimulus: rst_n=0 for 2 cycles, then btn=0001 held.
  - Response: all outputs 0; btn_db=0001 exactly 6 cycles after the btn edge.
  - Stimulus: btn[1] pulse 3 cycles long.
  - Response: btn_db[1] never rises.
- Hit:
  - Stimulus: en=1, beat, then arrow=0101; press btn[0] and btn[2] in the window; beat.
  - Response: judge=01 and judge_valid=1 one cycle after the beat; hit_bcd=0001; err_bcd=0000.
- Miss plus wrong press:
  - Stimulus: arrow=1000; press btn[1] only; beat.
  - Response: err_bcd=0001 after the press; judge=10 after the beat; err_bcd=0002.
- Same-cycle press:
  - Stimulus: arrow=0010; btn_db[1] rises in the beat cycle.
  - Response: hit.
  - Stimulus: arrow=0000; beat.
  - Response: no judge_valid; counters unchanged.
- BCD carry and saturation:
  - Stimulus: preload to 0009 with misses, then one more miss.
  - Response: err_bcd=0010.
  - Stimulus: drive to 9999, then one more miss.
  - Response: err_bcd stays 9999.
- Mode and clear:
  - Stimulus: en drops to 0 mid-window.
  - Response: IDLE, no verdict at the next beat.
  - Stimulus: clr at the beat cycle.
  - Response: counters=0, no judge_valid.
  - Stimulus: rst_n=0 mid-window.
  - Response: all outputs 0 next cycle.

Source files
------------

// File: rtl/dr_pkg.sv
// Shared definitions for the dance-game player judge: verdict codes, FSM
// encoding and saturating BCD arithmetic for the score tallies.
package dr_pkg;

    localparam logic [1:0] JUDGE_NONE = 2'b00;
    localparam logic [1:0] JUDGE_HIT  = 2'b01;
    localparam logic [1:0] JUDGE_MISS = 2'b10;

    localparam logic [15:0] BCD_MAX = 16'h9999;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_PLAY  = 2'd2
    } state_e;

    // Ripple a +1 through four BCD digits; wraps at 9999, callers guard it.
    function automatic logic [15:0] bcd_inc1(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int d = 0; d < 4; d++) begin
            if (carry) begin
                if (r[d*4 +: 4] == 4'd9) begin
                    r[d*4 +: 4] = 4'd0;
                end else begin
                    r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] bcd_add_sat(input logic [15:0] v, input logic [1:0] inc);
        logic [15:0] r;
        r = v;
        for (int k = 0; k < 2; k++) begin
            if ((2'(k) < inc) && (r != BCD_MAX)) r = bcd_inc1(r);
        end
        return r;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One arrow button: 2-FF synchronizer followed by a stable-count debouncer
// that toggles its output after DEB_CYCLES consecutive differing samples.
module btn_debounce
    import dr_pkg::*;
#(
    parameter int DEB_CYCLES = 1000,
    parameter int DEB_W      = 22
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic btn_db
);

    localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             db_q, db_d;
    logic [DEB_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = btn;
        sync2_d = sync1_q;
        cnt_d   = '0;
        db_d    = db_q;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_LAST) db_d  = ~db_q;
            else                   cnt_d = cnt_q + DEB_W'(1);
        end
    end

    // NOTE: reset is synchronous, so it is an ordinary branch of the clocked block.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign btn_db = db_q;

endmodule

// File: rtl/step_judge.sv
// Per-player step judge: debounces the four arrow buttons, collects presses
// over a beat window and issues hit/miss verdicts with BCD score tallies.
module step_judge
    import dr_pkg::*;
#(
    parameter int DEB_CYCLES = 1000,
    parameter int DEB_W      = 22
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        clr,
    input  logic        beat,
    input  logic [3:0]  arrow,
    input  logic [3:0]  btn,
    output logic [3:0]  btn_db,
    output logic [15:0] hit_bcd,
    output logic [15:0] err_bcd,
    output logic [1:0]  judge,
    output logic        judge_valid
);

    for (genvar i = 0; i < 4; i++) begin : g_deb
        btn_debounce #(
            .DEB_CYCLES(DEB_CYCLES),
            .DEB_W     (DEB_W)
        ) u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .btn   (btn[i]),
            .btn_db(btn_db[i])
        );
    end

    state_e      state_q, state_d;
    logic [3:0]  mask_q, mask_d;
    logic [3:0]  db_prev_q, db_prev_d;
    logic [15:0] hit_q, hit_d;
    logic [15:0] err_q, err_d;
    logic [1:0]  judge_q, judge_d;
    logic        jv_q, jv_d;

    logic [3:0]  press;
    logic [3:0]  mask_next;
    logic        wrong;
    logic        verdict_hit;
    logic        verdict_miss;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        judge_d      = judge_q;
        jv_d         = 1'b0;
        db_prev_d    = btn_db;
        press        = btn_db & ~db_prev_q;
        mask_next    = mask_q | (press & arrow);
        wrong        = 1'b0;
        verdict_hit  = 1'b0;
        verdict_miss = 1'b0;

        case (state_q)
            ST_IDLE: begin
                mask_d = '0;
                if (en) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                mask_d = '0;
                if (!en)       state_d = ST_IDLE;
                else if (beat) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (!en) begin
                    state_d = ST_IDLE;
                    mask_d  = '0;
                end else begin
                    wrong  = |(press & ~arrow);
                    mask_d = mask_next;
                    if (beat) begin
                        mask_d = '0;
                        if (arrow != 4'b0000) begin
                            verdict_hit  = ((mask_next & arrow) == arrow);
                            verdict_miss = ~verdict_hit;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A wrong press and a miss in the same beat cycle add 2 at once.
        hit_d = bcd_add_sat(hit_q, {1'b0, verdict_hit});
        err_d = bcd_add_sat(err_q, {1'b0, wrong} + {1'b0, verdict_miss});
        if (verdict_hit || verdict_miss) begin
            judge_d = verdict_hit ? JUDGE_HIT : JUDGE_MISS;
            jv_d    = 1'b1;
        end

        if (clr) begin
            hit_d   = '0;
            err_d   = '0;
            judge_d = JUDGE_NONE;
            jv_d    = 1'b0;
            mask_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            mask_q    <= '0;
            db_prev_q <= '0;
            hit_q     <= '0;
            err_q     <= '0;
            judge_q   <= JUDGE_NONE;
            jv_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            db_prev_q <= db_prev_d;
            hit_q     <= hit_d;
            err_q     <= err_d;
            judge_q   <= judge_d;
            jv_q      <= jv_d;
        end
    end

    assign hit_bcd     = hit_q;
    assign err_bcd     = err_q;
    assign judge       = judge_q;
    assign judge_valid = jv_q;

endmodule

// File: tb/tb_step_judge.sv
// Self-checking bench for step_judge with a 4-cycle debounce: a table of beat
// windows scored through an expectation queue, plus hand-written corner cases.
module tb_step_judge;
    import dr_pkg::*;

    localparam int DEB = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        clr = 1'b0;
    logic        beat = 1'b0;
    logic [3:0]  arrow = 4'b0000;
    logic [3:0]  btn = 4'b0000;
    logic [3:0]  btn_db;
    logic [15:0] hit_bcd;
    logic [15:0] err_bcd;
    logic [1:0]  judge;
    logic        judge_valid;

    int n_vec = 0;
    int n_err = 0;

    step_judge #(
        .DEB_CYCLES(DEB),
        .DEB_W     (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .clr        (clr),
        .beat       (beat),
        .arrow      (arrow),
        .btn        (btn),
        .btn_db     (btn_db),
        .hit_bcd    (hit_bcd),
        .err_bcd    (err_bcd),
        .judge      (judge),
        .judge_valid(judge_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]  arrow;
        logic [3:0]  p1;
        logic [3:0]  p2;
        logic [3:0]  same;
        logic [15:0] pre_err;
        logic        valid;
        logic [1:0]  judge;
        logic [15:0] hit;
        logic [15:0] err;
    } vec_t;

    typedef struct {
        logic        valid;
        logic [1:0]  judge;
        logic [15:0] hit;
        logic [15:0] err;
    } exp_t;

    vec_t vecs[8];
    exp_t sb[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_db(input logic [3:0] m, input string name);
        for (int k = 0; k < 20 && btn_db !== m; k++) tick();
        check(name, 16'(btn_db), 16'(m));
    endtask

    // Full press/release; the press pulse is consumed by the edge after btn_db rises.
    task automatic press(input logic [3:0] m);
        btn = m;
        wait_db(m, "press_db");
        btn = 4'b0000;
        tick();
        wait_db(4'b0000, "release_db");
    endtask

    task automatic beat_and_score(input exp_t e);
        exp_t got;
        beat = 1'b1;
        sb.push_back(e);
        tick();
        beat = 1'b0;
        got = sb.pop_front();
        check("verdict_valid", 16'(judge_valid), 16'(got.valid));
        check("verdict_judge", 16'(judge), 16'(got.judge));
        check("verdict_hit", hit_bcd, got.hit);
        check("verdict_err", err_bcd, got.err);
        tick();
        check("valid_pulse", 16'(judge_valid), 16'h0);
    endtask

    initial begin
        int   n;
        logic seen;
        exp_t e;

        vecs[0] = '{4'b0101, 4'b0001, 4'b0100, 4'b0000, 16'h0000, 1'b1, JUDGE_HIT,  16'h0001, 16'h0000};
        vecs[1] = '{4'b1000, 4'b0010, 4'b0000, 4'b0000, 16'h0001, 1'b1, JUDGE_MISS, 16'h0001, 16'h0002};
        vecs[2] = '{4'b0010, 4'b0000, 4'b0000, 4'b0010, 16'h0002, 1'b1, JUDGE_HIT,  16'h0002, 16'h0002};
        vecs[3] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 16'h0002, 1'b0, JUDGE_HIT,  16'h0002, 16'h0002};
        vecs[4] = '{4'b0011, 4'b0001, 4'b0000, 4'b0000, 16'h0002, 1'b1, JUDGE_MISS, 16'h0002, 16'h0003};
        vecs[5] = '{4'b0100, 4'b0000, 4'b0000, 4'b1100, 16'h0003, 1'b1, JUDGE_HIT,  16'h0003, 16'h0004};
        vecs[6] = '{4'b0001, 4'b0000, 4'b0000, 4'b0010, 16'h0004, 1'b1, JUDGE_MISS, 16'h0003, 16'h0006};
        vecs[7] = '{4'b0110, 4'b0010, 4'b0100, 4'b0000, 16'h0006, 1'b1, JUDGE_HIT,  16'h0004, 16'h0006};

        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_btn_db", 16'(btn_db), 16'h0);
        check("rst_hit", hit_bcd, 16'h0);
        check("rst_err", err_bcd, 16'h0);
        check("rst_judge", 16'(judge), 16'(JUDGE_NONE));
        check("rst_valid", 16'(judge_valid), 16'h0);
        rst_n = 1'b1;
        tick();

        // Debounce latency: 2 sync stages + DEB stable cycles
        btn = 4'b0001;
        n = 0;
        while (btn_db[0] !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("deb_latency", 16'(n), 16'(2 + DEB));
        check("deb_level", 16'(btn_db), 16'h1);
        btn = 4'b0000;
        wait_db(4'b0000, "deb_release");

        // Glitch one cycle shorter than DEB must be filtered
        seen = 1'b0;
        btn  = 4'b0010;
        for (int k = 0; k < 13; k++) begin
            if (k == DEB - 1) btn = 4'b0000;
            tick();
            seen |= btn_db[1];
        end
        check("glitch_filtered", 16'(seen), 16'h0);

        // Arm and start play: the first beat is never judged
        en = 1'b1;
        tick();
        beat = 1'b1;
        tick();
        beat = 1'b0;
        check("armed_beat_no_verdict", 16'(judge_valid), 16'h0);
        tick();

        for (int i = 0; i < 8; i++) begin
            arrow = vecs[i].arrow;
            if (vecs[i].p1 != 4'b0000) press(vecs[i].p1);
            if (vecs[i].p2 != 4'b0000) press(vecs[i].p2);
            check("pre_beat_err", err_bcd, vecs[i].pre_err);
            e = '{vecs[i].valid, vecs[i].judge, vecs[i].hit, vecs[i].err};
            if (vecs[i].same != 4'b0000) begin
                btn = vecs[i].same;
                wait_db(vecs[i].same, "same_cycle_db");
                beat_and_score(e);
                btn = 4'b0000;
                wait_db(4'b0000, "same_cycle_release");
            end else begin
                beat_and_score(e);
            end
        end

        // BCD carry: 6 -> 9 with misses, then 9 -> 10
        arrow = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            beat = 1'b1;
            tick();
            beat = 1'b0;
            tick();
        end
        check("err_0009", err_bcd, 16'h0009);
        e = '{1'b1, JUDGE_MISS, 16'h0004, 16'h0010};
        beat_and_score(e);

        // Wrong press lands in err one cycle after the press cycle
        arrow = 4'b1000;
        btn   = 4'b0010;
        wait_db(4'b0010, "wrong_db");
        check("wrong_not_yet", err_bcd, 16'h0010);
        tick();
        check("wrong_counted", err_bcd, 16'h0011);
        btn = 4'b0000;
        wait_db(4'b0000, "wrong_release");

        // Saturation: a miss every cycle from 11 up to 9999
        arrow = 4'b0001;
        beat  = 1'b1;
        for (int k = 0; k < 9987; k++) tick();
        check("err_9998", err_bcd, 16'h9998);
        tick();
        check("err_9999", err_bcd, 16'h9999);
        tick();
        check("err_saturated", err_bcd, 16'h9999);
        check("hit_unchanged", hit_bcd, 16'h0004);
        beat = 1'b0;
        tick();

        // clr in the beat cycle suppresses the verdict and clears the mask
        arrow = 4'b0001;
        press(4'b0001);
        beat = 1'b1;
        clr  = 1'b1;
        tick();
        beat = 1'b0;
        clr  = 1'b0;
        check("clr_hit", hit_bcd, 16'h0);
        check("clr_err", err_bcd, 16'h0);
        check("clr_judge", 16'(judge), 16'(JUDGE_NONE));
        check("clr_valid", 16'(judge_valid), 16'h0);
        tick();
        check("clr_valid_after", 16'(judge_valid), 16'h0);
        e = '{1'b1, JUDGE_MISS, 16'h0000, 16'h0001};
        beat_and_score(e);

        // en drop mid-window: back to IDLE, no verdict, mask discarded
        press(4'b0001);
        en = 1'b0;
        tick();
        beat = 1'b1;
        tick();
        beat = 1'b0;
        check("idle_no_verdict", 16'(judge_valid), 16'h0);
        check("idle_err_hold", err_bcd, 16'h0001);
        check("idle_hit_hold", hit_bcd, 16'h0000);
        en = 1'b1;
        tick();
        beat = 1'b1;
        tick();
        beat = 1'b0;
        check("rearm_no_verdict", 16'(judge_valid), 16'h0);
        tick();
        e = '{1'b1, JUDGE_MISS, 16'h0000, 16'h0002};
        beat_and_score(e);

        // Reset mid-window with a button held
        btn = 4'b0001;
        wait_db(4'b0001, "hold_db");
        rst_n = 1'b0;
        tick();
        check("midrst_btn_db", 16'(btn_db), 16'h0);
        check("midrst_hit", hit_bcd, 16'h0);
        check("midrst_err", err_bcd, 16'h0);
        check("midrst_judge", 16'(judge), 16'(JUDGE_NONE));
        check("midrst_valid", 16'(judge_valid), 16'h0);
        rst_n = 1'b1;
        btn   = 4'b0000;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
